// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline; outputs are combinational from state and inputs, no added latency.
// Never backpressured itself: it is the source of every hold/bubble, and all outputs are forced low while reset is asserted.
module hazard_controller #(
  parameter int N                 = 5,
  parameter int TIMEOUT_CYCLES    = 255,
  parameter int TRAP_DRAIN_CYCLES = 2,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         rs1_id,
  input  logic [N-1:0]         rs2_id,
  input  logic                 uses_rs1_id,
  input  logic                 uses_rs2_id,
  input  logic                 operand_in_id,
  input  logic [N-1:0]         rd_ex,
  input  logic [N-1:0]         rd_mem,
  input  logic                 reg_we_ex,
  input  logic                 reg_we_mem,
  input  logic                 mem_read_ex,
  input  logic                 mem_read_mem,
  input  logic                 branch_taken_id,
  input  logic                 trap_mem,
  input  logic                 imem_req,
  input  logic                 imem_ack,
  input  logic                 dmem_req,
  input  logic                 dmem_ack,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 stall_ex,
  output logic                 stall_mem,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 flush_mem,
  output logic                 flush_wb,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int DW = (TRAP_DRAIN_CYCLES > 1) ? $clog2(TRAP_DRAIN_CYCLES) : 1;
  localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(TRAP_DRAIN_CYCLES - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN} state_t;

  state_t         state;
  logic [DW-1:0]  drain_cnt;
  logic [WDW-1:0] wd_cnt;
  logic           timeout_q;
  logic           redirect_pending;

  logic ex_match, mem_match, load_use, dec_hz, d_wait, i_wait, timeout_hit, set_pend;

  // Register 0 is hardwired, so a match against it is never a hazard.
  assign ex_match  = (rd_ex != '0) &&
                     ((uses_rs1_id && rs1_id == rd_ex) || (uses_rs2_id && rs2_id == rd_ex));
  assign mem_match = (rd_mem != '0) &&
                     ((uses_rs1_id && rs1_id == rd_mem) || (uses_rs2_id && rs2_id == rd_mem));
  assign load_use  = reg_we_ex && mem_read_ex && ex_match;
  assign dec_hz    = operand_in_id &&
                     ((reg_we_ex && ex_match) || (reg_we_mem && mem_read_mem && mem_match));
  assign d_wait    = dmem_req && !dmem_ack;
  assign i_wait    = imem_req && !imem_ack;
  assign timeout_hit = d_wait && (wd_cnt == WD_LAST);
  assign mem_timeout = reset && (timeout_q || timeout_hit);

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    set_pend  = 1'b0;
    if (d_wait) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else begin
      if (trap_mem) begin
        flush_id  = 1'b1;
        flush_ex  = 1'b1;
        flush_mem = 1'b1;
      end else if (load_use || dec_hz) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else if (branch_taken_id) begin
        // A redirect during a fetch wait is deferred until the stale fetch returns.
        if (i_wait) set_pend = 1'b1;
        else        flush_id = 1'b1;
      end else if (i_wait) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
      end
      if (state == DRAIN || (redirect_pending && imem_ack)) flush_id = 1'b1;
    end
    if (!reset) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      flush_mem = 1'b0;
      flush_wb  = 1'b0;
      set_pend  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= RUN;
      drain_cnt        <= '0;
      wd_cnt           <= '0;
      timeout_q        <= 1'b0;
      redirect_pending <= 1'b0;
      stall_count      <= '0;
    end else begin
      if (d_wait) begin
        // A data wait inside a drain keeps the drain state with its counter frozen.
        if (state != DRAIN) state <= DWAIT;
        if (wd_cnt != WD_LAST) wd_cnt <= wd_cnt + WDW'(1);
      end else begin
        wd_cnt <= '0;
        if (trap_mem) begin
          state     <= (TRAP_DRAIN_CYCLES > 1) ? DRAIN : RUN;
          drain_cnt <= DRAIN_LOAD;
        end else if (state == DRAIN) begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt <= DW'(1)) state <= RUN;
        end else begin
          state <= RUN;
        end
        if (redirect_pending) redirect_pending <= !(imem_ack && !branch_taken_id);
        else                  redirect_pending <= set_pend;
      end
      if (timeout_hit) timeout_q <= 1'b1;
      if (stall_if) stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and random checks of hazard_controller against a rule-level reference model.
module tb_hazard_controller;
  localparam int N = 5;
  localparam int TMO = 4;
  localparam int DRN = 2;
  localparam int CW = 32;

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0] rs1_id, rs2_id, rd_ex, rd_mem;
  logic uses_rs1_id, uses_rs2_id, operand_in_id, reg_we_ex, reg_we_mem;
  logic mem_read_ex, mem_read_mem, branch_taken_id, trap_mem;
  logic imem_req, imem_ack, dmem_req, dmem_ack;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic flush_id, flush_ex, flush_mem, flush_wb, mem_timeout;
  logic [CW-1:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, counted in plain integers.
  int          m_drain_left;
  bit          m_pend;
  int          m_wait_run;
  bit          m_tmo;
  logic [CW-1:0] m_cnt;

  hazard_controller #(.N(N), .TIMEOUT_CYCLES(TMO), .TRAP_DRAIN_CYCLES(DRN), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id),
    .operand_in_id(operand_in_id), .rd_ex(rd_ex), .rd_mem(rd_mem),
    .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem),
    .mem_read_ex(mem_read_ex), .mem_read_mem(mem_read_mem),
    .branch_taken_id(branch_taken_id), .trap_mem(trap_mem),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  function automatic bit reads(input logic [N-1:0] rd);
    return (rd != 0) && ((uses_rs1_id && rs1_id == rd) || (uses_rs2_id && rs2_id == rd));
  endfunction

  // Bit order: stall_if stall_id stall_ex stall_mem flush_id flush_ex flush_mem flush_wb mem_timeout
  function automatic logic [8:0] model_out();
    logic [8:0] o;
    bit dw, iw, hz;
    o  = '0;
    dw = dmem_req && !dmem_ack;
    iw = imem_req && !imem_ack;
    hz = (reg_we_ex && mem_read_ex && reads(rd_ex)) ||
         (operand_in_id && ((reg_we_ex && reads(rd_ex)) || (reg_we_mem && mem_read_mem && reads(rd_mem))));
    if (dw) o = 9'b111100010;
    else begin
      if (trap_mem) o = 9'b000011100;
      else if (hz) o = 9'b110001000;
      else if (branch_taken_id) o = iw ? 9'b000000000 : 9'b000010000;
      else if (iw) o = 9'b100010000;
      if (m_drain_left > 0 || (m_pend && imem_ack)) o[4] = 1'b1;
    end
    o[0] = m_tmo || (dw && (m_wait_run + 1 >= TMO));
    return o;
  endfunction

  task automatic model_advance(input logic [8:0] o);
    bit dw, iw, hz;
    dw = dmem_req && !dmem_ack;
    iw = imem_req && !imem_ack;
    hz = o[8] && !dw;
    if (dw) m_wait_run++;
    else begin
      m_wait_run = 0;
      if (trap_mem) m_drain_left = DRN - 1;
      else if (m_drain_left > 0) m_drain_left--;
      if (m_pend) m_pend = !(imem_ack && !branch_taken_id);
      else m_pend = branch_taken_id && iw && !trap_mem && !hz;
    end
    if (o[0]) m_tmo = 1'b1;
    if (o[8]) m_cnt = m_cnt + 1;
  endtask

  task automatic model_reset();
    m_drain_left = 0; m_pend = 0; m_wait_run = 0; m_tmo = 0; m_cnt = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] obs_vec();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb, mem_timeout};
  endfunction

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_ex = 0; rd_mem = 0;
    uses_rs1_id = 0; uses_rs2_id = 0; operand_in_id = 0; reg_we_ex = 0; reg_we_mem = 0;
    mem_read_ex = 0; mem_read_mem = 0; branch_taken_id = 0; trap_mem = 0;
    imem_req = 0; imem_ack = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // One clock cycle: sample on the falling edge, optionally against a fixed expectation too.
  task automatic step(input string tag, input bit fixed, input logic [8:0] want);
    logic [8:0] e;
    @(negedge clock);
    e = model_out();
    check({tag, "_out"}, 32'(obs_vec()), 32'(e));
    check({tag, "_cnt"}, stall_count, m_cnt);
    if (fixed) check({tag, "_fixed"}, 32'(obs_vec()), 32'(want));
    model_advance(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    #2;
    check("reset_out", 32'(obs_vec()), 32'd0);
    check("reset_cnt", stall_count, 32'd0);
    #10 reset = 1'b1;
    @(posedge clock); #1;

    // Load-use, then the same against register 0.
    mem_read_ex = 1; reg_we_ex = 1; rd_ex = 5; rs1_id = 5; uses_rs1_id = 1;
    step("lu", 1, 9'b110001000);
    rd_ex = 0; rs1_id = 0;
    step("lu_r0", 1, 9'b000000000);
    check("lu_count", stall_count, 32'd1);

    // Decode-stage operand hazard on a load in MEM, then a non-load.
    idle();
    operand_in_id = 1; rs2_id = 7; uses_rs2_id = 1; reg_we_mem = 1; mem_read_mem = 1; rd_mem = 7;
    step("dh", 1, 9'b110001000);
    mem_read_mem = 0;
    step("dh_noload", 1, 9'b000000000);

    // Data wait masks a trap; the trap lands on the ack cycle and drains one more cycle.
    idle();
    dmem_req = 1; trap_mem = 1;
    for (int i = 0; i < 3; i++) step("dwait", 1, 9'b111100010);
    dmem_ack = 1;
    step("trap_ack", 1, 9'b000011100);
    idle();
    step("drain", 1, 9'b000010000);
    step("drain_end", 1, 9'b000000000);

    // Taken branch during a fetch wait is deferred to the ack cycle.
    branch_taken_id = 1; imem_req = 1;
    step("redir_wait0", 1, 9'b000000000);
    step("redir_wait1", 1, 9'b000000000);
    branch_taken_id = 0; imem_ack = 1;
    step("redir_ack", 1, 9'b000010000);
    idle();
    step("redir_done", 1, 9'b000000000);

    // Watchdog fires on the fourth consecutive wait cycle and stays set.
    dmem_req = 1;
    for (int i = 0; i < 3; i++) step("wd_wait", 1, 9'b111100010);
    step("wd_fire", 1, 9'b111100011);
    dmem_ack = 1;
    step("wd_ack", 1, 9'b000000001);
    idle();
    step("wd_sticky", 1, 9'b000000001);

    // Asynchronous reset between edges in the middle of a data wait.
    dmem_req = 1;
    step("pre_rst", 1, 9'b111100011);
    #3 reset = 1'b0;
    #1;
    check("async_rst_out", 32'(obs_vec()), 32'd0);
    check("async_rst_cnt", stall_count, 32'd0);
    model_reset();
    idle();
    #2 reset = 1'b1;
    @(posedge clock); #1;
    step("post_rst", 1, 9'b000000000);

    // Random traffic with a small register range so hazards are frequent.
    for (int i = 0; i < 800; i++) begin
      rs1_id = N'($urandom_range(0, 3)); rs2_id = N'($urandom_range(0, 3));
      rd_ex = N'($urandom_range(0, 3));  rd_mem = N'($urandom_range(0, 3));
      uses_rs1_id = 1'($urandom); uses_rs2_id = 1'($urandom);
      operand_in_id = 1'($urandom); reg_we_ex = 1'($urandom); reg_we_mem = 1'($urandom);
      mem_read_ex = 1'($urandom); mem_read_mem = 1'($urandom);
      branch_taken_id = ($urandom_range(0, 4) == 0);
      trap_mem = ($urandom_range(0, 11) == 0);
      imem_req = 1'($urandom); imem_ack = 1'($urandom);
      dmem_req = 1'($urandom); dmem_ack = ($urandom_range(0, 2) == 0);
      step("rand", 0, 9'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline stall/flush sequencer for the 5-stage core.
- Consumes the register-address and handshake information the forwarding unit also sees.
- Decides, each cycle, which pipeline registers hold (stall) and which are loaded with a bubble (flush). Covers hazards forwarding cannot resolve: load-use, decode-stage operand, instruction/data memory wait, taken branch and trap.
- Tracks multi-cycle conditions (memory wait, pending redirect, trap drain), a wait watchdog and a stall-cycle counter.

Parameters:
N, 5, register index width
TIMEOUT_CYCLES, 255, consecutive data-memory wait cycles before mem_timeout
TRAP_DRAIN_CYCLES, 2, cycles IF/ID is held flushed after a trap
CNT_WIDTH, 32, stall_count width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low (0 = reset)
rs1_id, rs2_id  in  N  source registers in ID
uses_rs1_id, uses_rs2_id  in  1  ID actually reads rs1/rs2
operand_in_id  in  1  ID consumes operands in ID (branch compare)
rd_ex, rd_mem  in  N  destinations in EX/MEM
reg_we_ex, reg_we_mem  in  1  destination write enables
mem_read_ex, mem_read_mem  in  1  instruction in EX/MEM is a load
branch_taken_id  in  1  redirect resolved in ID
trap_mem  in  1  trap raised by MEM instruction
imem_req, imem_ack  in  1  fetch request / completion
dmem_req, dmem_ack  in  1  MEM-stage access / completion
stall_if, stall_id, stall_ex, stall_mem  out  1  hold PC / IF-ID / ID-EX / EX-MEM
flush_id, flush_ex, flush_mem, flush_wb  out  1  bubble into IF-ID / ID-EX / EX-MEM / MEM-WB
mem_timeout  out  1  sticky watchdog error
stall_count  out  CNT_WIDTH  cycles with stall_if=1

Behaviour:
- Reset (reset=0, async):
  - State RUN; redirect_pending=0; drain and watchdog counters 0.
  - stall_count=0; mem_timeout=0; all stall/flush outputs 0.
- Matches against register 0 never count as a hazard.
- Outputs are combinational from state and inputs. Counters and flags update on the rising clock edge.
- Hazard terms:
  - LU = reg_we_ex & mem_read_ex & match(rd_ex).
  - DH = operand_in_id & ((reg_we_ex & match(rd_ex)) | (reg_we_mem & mem_read_mem & match(rd_mem))).
  - match(rd) = (uses_rs1_id & rs1_id==rd) | (uses_rs2_id & rs2_id==rd).
- Priority, highest first; exactly one rule applies per cycle:
  1. D-wait (dmem_req & !dmem_ack): stall_if, stall_id, stall_ex, stall_mem = 1; flush_wb = 1; everything else 0. trap_mem and branch_taken_id are ignored this cycle.
  2. Trap (trap_mem): flush_id, flush_ex, flush_mem = 1; no stalls; enter DRAIN.
  3. LU or DH: stall_if, stall_id = 1; flush_ex = 1; branch_taken_id is ignored.
  4. branch_taken_id: flush_id = 1. If imem_req & !imem_ack in the same cycle, set redirect_pending and do not flush.
  5. I-wait (imem_req & !imem_ack): stall_if = 1; flush_id = 1.
- State machine:
  - RUN → DWAIT when rule 1 applies.
  - DWAIT → RUN on the cycle dmem_ack=1 (no stall that cycle).
  - RUN → DRAIN on trap.
  - DRAIN forces flush_id=1 for TRAP_DRAIN_CYCLES cycles counting the trap cycle, then returns to RUN. Rule 1 may still preempt while in DRAIN; the drain counter freezes meanwhile.
  - A new trap_mem during DRAIN reloads the counter.
- redirect_pending: while set, the cycle imem_ack=1 forces flush_id=1 (squashes the stale fetch), then clears. branch_taken_id while it is set keeps it set.
- Watchdog:
  - Counts consecutive DWAIT cycles; clears on dmem_ack.
  - Reaching TIMEOUT_CYCLES sets mem_timeout, which stays at 1 until reset. Stalling continues regardless.
- stall_count: increments when stall_if=1, wraps at 2^CNT_WIDTH.
- Reset mid-wait or mid-drain: immediate return to reset values. Pending redirect is discarded.

Test Plan:
1. Load-use: mem_read_ex=1, reg_we_ex=1, rd_ex=5, rs1_id=5, uses_rs1_id=1 → stall_if=stall_id=flush_ex=1 for 1 cycle; stall_count +1. Same with rd_ex=0 → all outputs 0.
2. Decode operand: operand_in_id=1, rs2_id=7, uses_rs2_id=1, reg_we_mem=mem_read_mem=1, rd_mem=7 → stall+bubble. Same with mem_read_mem=0 → no stall.
3. Data wait: dmem_req=1, dmem_ack=0 for 3 cycles with trap_mem=1 → 3 cycles of stall_if..stall_mem=1, flush_wb=1. Ack on cycle 4 → flush_id/ex/mem=1, then flush_id=1 for 1 more cycle (TRAP_DRAIN_CYCLES=2).
4. Redirect during fetch wait: branch_taken_id=1, imem_req=1, imem_ack=0 → flush_id=0. Ack 2 cycles later → flush_id=1 exactly on the ack cycle, 0 after.
5. Watchdog (TIMEOUT_CYCLES=4): dmem_ack held 0 for 4 cycles → mem_timeout=1 on cycle 4 and stays 1 after ack, until reset=0.
6. Async reset asserted mid-DWAIT between clock edges → all outputs 0 immediately, stall_count=0.
